rf68000_plic_gw: RTL and testbench

Parametrised interrupt controller for the rf68000 system bus with per-source gateways, priorities and threshold, and a claim/complete handshake. It extends the existing 32-input priority encoder to up to 64 sources. Edge and level sources are gated so each request is delivered exactly once until software completes it. It sits between peripheral interrupt lines and the CPU `irq`/`nmi` inputs, and answers 68000 interrupt-acknowledge (IACK) cycles with a vector or a VPA autovector request.

---
 rtl/rf68000_plic_gw.sv | 241 ++++++++++++++++++++++++
 tb/tb_rf68000_plic_gw.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf68000_plic_gw.sv
// Interrupt controller for the rf68000 bus: per-source gateways, priority/threshold
// arbitration, claim/complete registers and 68000 IACK vector or autovector answers.
module rf68000_plic_gw #(
    parameter int NSRC   = 64,
    parameter int CORE_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              wr_i,
    input  logic [2:0]        fc_i,
    input  logic [31:0]       adr_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    output logic              vpa_o,
    input  logic [NSRC-1:0]   irq_i,
    input  logic              nmi_i,
    output logic              nmi_o,
    output logic [2:0]        irq_o,
    output logic [7:0]        cause_o,
    output logic [5:0]        id_o,
    output logic [CORE_W-1:0] core_o
);

    typedef enum logic [1:0] {GW_IDLE = 2'd0, GW_PEND = 2'd1, GW_SERV = 2'd2} gw_state_t;

    localparam logic [NSRC-1:0] SRC_MASK = {{(NSRC-1){1'b1}}, 1'b0};
    localparam logic [NSRC-1:0] ONE_HOT0 = {{(NSRC-1){1'b0}}, 1'b1};

    function automatic logic [31:0] ctl_word(input logic [7:0] cause, input logic [2:0] prio,
                                             input logic ie, input logic es, input logic av,
                                             input logic [CORE_W-1:0] core);
        logic [31:0] w;
        w              = 32'd0;
        w[7:0]         = cause;
        w[10:8]        = prio;
        w[16]          = ie;
        w[17]          = es;
        w[18]          = av;
        w[24 +: CORE_W] = core;
        return w;
    endfunction

    logic [7:0]        cause_r [NSRC];
    logic [2:0]        prio_r  [NSRC];
    logic [CORE_W-1:0] core_r  [NSRC];
    logic [NSRC-1:0]   ie_r, es_r, av_r;
    logic [2:0]        thr_r;
    logic              nmie_r;
    gw_state_t         gw_r    [NSRC];
    gw_state_t         gw_nx_s [NSRC];
    logic [NSRC-1:0]   irq_q_r, irq_qq_r, edge_r, edge_nx_s;
    logic [NSRC-1:0]   req_s, move_s, trig_vec_s, pend_s, serv_s, idle_s, cand_s;
    logic [63:0]       pend_w_s, serv_w_s;
    logic [5:0]        win_id_s;
    logic [2:0]        win_prio_s;
    logic [7:0]        win_cause_s;
    logic [CORE_W-1:0] win_core_s;
    logic              win_av_s, win_vld_s;
    logic [8:0]        off_s;
    logic              bus_s, is_iack_s, iack_s, reg_s, reg_wr_s, busy_s;
    logic              reg_rd_start_s, iack_start_s, iack_ok_s, claim_s, cmpl_s, trig_s;
    logic [31:0]       rd_data_s;
    logic              rd_ack_r, vpa_r;
    logic              unused_s;

    assign off_s          = adr_i[10:2];
    assign bus_s          = cyc_i & stb_i;
    assign is_iack_s      = (fc_i == 3'b111) && (&adr_i[31:4]);
    assign iack_s         = bus_s & is_iack_s;
    assign reg_s          = bus_s & cs_i & ~is_iack_s;
    assign reg_wr_s       = reg_s & wr_i;
    assign busy_s         = rd_ack_r | vpa_r;
    assign reg_rd_start_s = reg_s & ~wr_i & ~busy_s;
    assign iack_start_s   = iack_s & ~busy_s;
    assign iack_ok_s      = win_vld_s && (adr_i[3:1] >= win_prio_s);
    // A claim happens once per bus cycle, on the edge that raises ack or vpa.
    assign claim_s        = (reg_rd_start_s && (off_s == 9'h000)) || (iack_start_s && iack_ok_s);
    assign cmpl_s         = reg_wr_s && (off_s == 9'h000);
    assign trig_s         = reg_wr_s && (off_s == 9'h002);
    assign trig_vec_s     = trig_s ? (ONE_HOT0 << dat_i[5:0]) : {NSRC{1'b0}};
    assign ack_o          = ~rst_i & ((reg_s & wr_i) | (rd_ack_r & bus_s));
    assign vpa_o          = ~rst_i & vpa_r & bus_s;
    assign unused_s       = ^{adr_i[1:0], dat_i[31:30], dat_i[23:19], dat_i[15:11]};

    // Source configuration, threshold and NMI enable registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NSRC; n++) begin
                cause_r[n] <= 8'd0;
                prio_r[n]  <= 3'd0;
                core_r[n]  <= {CORE_W{1'b0}};
            end
            ie_r   <= {NSRC{1'b0}};
            es_r   <= {NSRC{1'b1}};
            av_r   <= {NSRC{1'b0}};
            thr_r  <= 3'd0;
            nmie_r <= 1'b0;
        end else begin
            if (reg_wr_s && (off_s == 9'h001)) begin
                thr_r  <= dat_i[2:0];
                nmie_r <= dat_i[8];
            end
            for (int n = 1; n < NSRC; n++) begin
                if (reg_wr_s && (off_s == {1'b1, 8'(n)})) begin
                    cause_r[n] <= dat_i[7:0];
                    prio_r[n]  <= dat_i[10:8];
                    ie_r[n]    <= dat_i[16];
                    es_r[n]    <= dat_i[17];
                    av_r[n]    <= dat_i[18];
                    core_r[n]  <= dat_i[24 +: CORE_W];
                end
            end
        end
    end

    // Gateway state register, edge latches and two-stage input registration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < NSRC; n++) gw_r[n] <= GW_IDLE;
            irq_q_r  <= {NSRC{1'b0}};
            irq_qq_r <= {NSRC{1'b0}};
            edge_r   <= {NSRC{1'b0}};
        end else begin
            for (int n = 0; n < NSRC; n++) gw_r[n] <= gw_nx_s[n];
            irq_q_r  <= irq_i;
            irq_qq_r <= irq_q_r;
            edge_r   <= edge_nx_s;
        end
    end

    // Gateway next state; an edge seen outside IDLE stays latched until it can pend.
    always_comb begin
        req_s     = ((es_r & edge_r) | (~es_r & irq_i)) & SRC_MASK;
        move_s    = idle_s & es_r & edge_r;
        edge_nx_s = ((edge_r & ~move_s) | (irq_q_r & ~irq_qq_r & es_r) | trig_vec_s) & SRC_MASK;
        for (int n = 0; n < NSRC; n++) begin
            gw_nx_s[n] = gw_r[n];
            case (gw_r[n])
                GW_IDLE: gw_nx_s[n] = req_s[n] ? GW_PEND : GW_IDLE;
                GW_PEND: gw_nx_s[n] = (claim_s && (win_id_s == 6'(n))) ? GW_SERV : GW_PEND;
                GW_SERV: gw_nx_s[n] = (cmpl_s && (dat_i[5:0] == 6'(n))) ? GW_IDLE : GW_SERV;
                default: gw_nx_s[n] = GW_IDLE;
            endcase
        end
    end

    // Gateway state decode into pending / in-service vectors.
    always_comb begin
        pend_s   = {NSRC{1'b0}};
        serv_s   = {NSRC{1'b0}};
        idle_s   = {NSRC{1'b0}};
        for (int n = 0; n < NSRC; n++) begin
            pend_s[n] = (gw_r[n] == GW_PEND);
            serv_s[n] = (gw_r[n] == GW_SERV);
            idle_s[n] = (gw_r[n] == GW_IDLE);
        end
        pend_w_s = 64'd0;
        serv_w_s = 64'd0;
        pend_w_s[NSRC-1:0] = pend_s;
        serv_w_s[NSRC-1:0] = serv_s;
    end

    // Arbitration: strict greater-than while scanning upward keeps the lowest id on ties.
    always_comb begin
        cand_s     = pend_s & ie_r;
        win_id_s   = 6'd0;
        win_prio_s = 3'd0;
        for (int n = 0; n < NSRC; n++) begin
            win_id_s   = (cand_s[n] && (prio_r[n] > win_prio_s)) ? 6'(n) : win_id_s;
            win_prio_s = (cand_s[n] && (prio_r[n] > win_prio_s)) ? prio_r[n] : win_prio_s;
        end
        win_vld_s   = (win_id_s != 6'd0);
        win_cause_s = cause_r[win_id_s];
        win_core_s  = core_r[win_id_s];
        win_av_s    = av_r[win_id_s];
    end

    // Register read multiplexer.
    always_comb begin
        rd_data_s = 32'd0;
        case (off_s)
            9'h000:  rd_data_s = {13'd0, win_prio_s, win_cause_s, 2'd0, win_id_s};
            9'h001:  rd_data_s = {23'd0, nmie_r, 5'd0, thr_r};
            9'h004:  rd_data_s = pend_w_s[31:0];
            9'h005:  rd_data_s = pend_w_s[63:32];
            9'h006:  rd_data_s = serv_w_s[31:0];
            9'h007:  rd_data_s = serv_w_s[63:32];
            default: begin
                for (int n = 1; n < NSRC; n++) begin
                    rd_data_s = (off_s == {1'b1, 8'(n)}) ?
                        ctl_word(cause_r[n], prio_r[n], ie_r[n], es_r[n], av_r[n], core_r[n]) :
                        rd_data_s;
                end
            end
        endcase
    end

    // Bus response: read data and ack/vpa arrive in the second strobe cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ack_r <= 1'b0;
            vpa_r    <= 1'b0;
            dat_o    <= 32'd0;
        end else if (!bus_s) begin
            rd_ack_r <= 1'b0;
            vpa_r    <= 1'b0;
        end else if (reg_rd_start_s) begin
            rd_ack_r <= 1'b1;
            dat_o    <= rd_data_s;
        end else if (iack_start_s) begin
            if (iack_ok_s && win_av_s) begin
                vpa_r <= 1'b1;
            end else begin
                rd_ack_r <= 1'b1;
                dat_o    <= iack_ok_s ? {4{win_cause_s}} : {4{8'd24}};
            end
        end
    end

    // Registered CPU-facing interrupt outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_o   <= 3'd0;
            cause_o <= 8'd0;
            id_o    <= 6'd0;
            core_o  <= {CORE_W{1'b0}};
            nmi_o   <= 1'b0;
        end else begin
            irq_o   <= (win_prio_s > thr_r) ? win_prio_s : 3'd0;
            cause_o <= win_cause_s;
            id_o    <= win_id_s;
            core_o  <= win_core_s;
            nmi_o   <= nmi_i & nmie_r;
        end
    end

endmodule

// File: tb/tb_rf68000_plic_gw.sv
// Directed self-checking bench for rf68000_plic_gw.
module tb_rf68000_plic_gw;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, cyc = 1'b0, stb = 1'b0, wr = 1'b0;
    logic [2:0]  fc = 3'b101;
    logic [31:0] adr = 32'd0, dat = 32'd0;
    logic [31:0] dat_o;
    logic        ack, vpa, nmi = 1'b0, nmi_o;
    logic [63:0] irq = 64'd0;
    logic [2:0]  irq_o;
    logic [7:0]  cause_o;
    logic [5:0]  id_o;
    logic [5:0]  core_o;
    int          n_total = 0;
    int          n_bad = 0;
    logic [31:0] id_data;
    logic        id_ack, id_vpa;

    rf68000_plic_gw #(.NSRC(64), .CORE_W(6)) dut (
        .clk_i(clk), .rst_i(rst), .cs_i(cs), .cyc_i(cyc), .stb_i(stb), .wr_i(wr),
        .fc_i(fc), .adr_i(adr), .dat_i(dat), .dat_o(dat_o), .ack_o(ack), .vpa_o(vpa),
        .irq_i(irq), .nmi_i(nmi), .nmi_o(nmi_o), .irq_o(irq_o), .cause_o(cause_o),
        .id_o(id_o), .core_o(core_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc_wait(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic bus_write(input logic [8:0] off, input logic [31:0] data);
        @(negedge clk);
        cs = 1'b1; cyc = 1'b1; stb = 1'b1; wr = 1'b1; fc = 3'b101;
        adr = {21'd0, off, 2'b00}; dat = data;
        @(negedge clk);
        cs = 1'b0; cyc = 1'b0; stb = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [8:0] off, input logic [31:0] exp);
        logic [31:0] d;
        logic        seen;
        d = 32'd0;
        seen = 1'b0;
        @(negedge clk);
        cs = 1'b1; cyc = 1'b1; stb = 1'b1; wr = 1'b0; fc = 3'b101;
        adr = {21'd0, off, 2'b00};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) begin
                seen = 1'b1;
                d = dat_o;
                break;
            end
        end
        cs = 1'b0; cyc = 1'b0; stb = 1'b0;
        chk({tag, "_ack"}, {31'd0, seen}, 32'd1);
        chk(tag, d, exp);
    endtask

    task automatic iack(input logic [2:0] lvl, output logic [31:0] d, output logic a, output logic v);
        d = 32'd0; a = 1'b0; v = 1'b0;
        @(negedge clk);
        cs = 1'b0; cyc = 1'b1; stb = 1'b1; wr = 1'b0; fc = 3'b111;
        adr = {28'hFFFFFFF, lvl, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack || vpa) begin
                a = ack; v = vpa; d = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; fc = 3'b101; adr = 32'd0;
    endtask

    initial begin
        // reset state
        cyc_wait(2);
        chk("rst_irq_o", {29'd0, irq_o}, 32'd0);
        chk("rst_id_o", {26'd0, id_o}, 32'd0);
        chk("rst_dat_o", dat_o, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_read("thr_reset", 9'h001, 32'd0);
        bus_read("ctl5_reset", 9'h105, 32'h0002_0000);

        // two level sources, equal priority: lowest id wins
        bus_write(9'h105, 32'h0001_03A5);
        bus_write(9'h109, 32'h0001_0399);
        irq[5] = 1'b1; irq[9] = 1'b1;
        cyc_wait(3);
        chk("tie_id", {26'd0, id_o}, 32'd5);
        chk("tie_irq", {29'd0, irq_o}, 32'd3);
        chk("tie_cause", {24'd0, cause_o}, 32'h0000_00A5);
        bus_read("pend_5_9", 9'h004, 32'h0000_0220);
        bus_read("claim5", 9'h000, 32'h0003_A505);
        cyc_wait(3);
        chk("next_id9", {26'd0, id_o}, 32'd9);
        bus_read("serv5", 9'h006, 32'h0000_0020);
        bus_read("pend9", 9'h004, 32'h0000_0200);
        bus_write(9'h000, 32'd5);
        cyc_wait(3);
        bus_read("repend5", 9'h004, 32'h0000_0220);
        chk("repend_id5", {26'd0, id_o}, 32'd5);
        irq[5] = 1'b0; irq[9] = 1'b0;
        bus_read("claim5b", 9'h000, 32'h0003_A505);
        bus_write(9'h000, 32'd5);
        bus_read("claim9", 9'h000, 32'h0003_9909);
        bus_write(9'h000, 32'd9);
        cyc_wait(3);
        chk("idle_irq", {29'd0, irq_o}, 32'd0);

        // threshold
        bus_write(9'h001, 32'd4);
        bus_write(9'h107, 32'h0001_0477);
        irq[7] = 1'b1;
        cyc_wait(3);
        chk("thr_id7", {26'd0, id_o}, 32'd7);
        chk("thr_eq_masked", {29'd0, irq_o}, 32'd0);
        bus_write(9'h001, 32'd3);
        cyc_wait(1);
        chk("thr_below", {29'd0, irq_o}, 32'd4);
        irq[7] = 1'b0;
        bus_read("claim7", 9'h000, 32'h0004_7707);
        bus_write(9'h000, 32'd7);
        bus_write(9'h001, 32'd0);

        // edge source 12: a pulse while in service waits for complete
        bus_write(9'h10C, 32'h0003_0212);
        irq[12] = 1'b1; cyc_wait(2); irq[12] = 1'b0;
        cyc_wait(4);
        chk("edge_id12", {26'd0, id_o}, 32'd12);
        chk("edge_irq", {29'd0, irq_o}, 32'd2);
        bus_read("claim12", 9'h000, 32'h0002_120C);
        irq[12] = 1'b1; cyc_wait(2); irq[12] = 1'b0;
        cyc_wait(4);
        bus_read("edge_held", 9'h004, 32'd0);
        chk("edge_held_irq", {29'd0, irq_o}, 32'd0);
        bus_write(9'h000, 32'd12);
        cyc_wait(4);
        bus_read("edge_repend", 9'h004, 32'h0000_1000);
        chk("edge_repend_irq", {29'd0, irq_o}, 32'd2);
        bus_read("claim12b", 9'h000, 32'h0002_120C);
        bus_write(9'h000, 32'd12);

        // IACK: vector, autovector, spurious
        bus_write(9'h103, 32'h0001_0640);
        irq[3] = 1'b1;
        cyc_wait(3);
        iack(3'd6, id_data, id_ack, id_vpa);
        chk("iack_vec", id_data, 32'h4040_4040);
        chk("iack_vec_ack", {30'd0, id_ack, id_vpa}, 32'd2);
        bus_read("iack_serv", 9'h006, 32'h0000_0008);
        bus_write(9'h000, 32'd3);
        bus_write(9'h103, 32'h0005_0640);
        cyc_wait(3);
        iack(3'd6, id_data, id_ack, id_vpa);
        chk("iack_av", {30'd0, id_ack, id_vpa}, 32'd1);
        bus_read("iack_av_serv", 9'h006, 32'h0000_0008);
        irq[3] = 1'b0;
        bus_write(9'h000, 32'd3);
        cyc_wait(3);
        iack(3'd6, id_data, id_ack, id_vpa);
        chk("iack_none", id_data, 32'h1818_1818);
        chk("iack_none_ack", {30'd0, id_ack, id_vpa}, 32'd2);
        bus_write(9'h103, 32'h0001_0640);
        irq[3] = 1'b1;
        cyc_wait(3);
        iack(3'd5, id_data, id_ack, id_vpa);
        chk("iack_low", id_data, 32'h1818_1818);
        bus_read("iack_low_pend", 9'h004, 32'h0000_0008);
        irq[3] = 1'b0;
        bus_read("claim3", 9'h000, 32'h0006_4003);
        bus_write(9'h000, 32'd3);

        // ignored writes, upper pending word, NMI
        bus_write(9'h000, 32'd20);
        bus_write(9'h002, 32'd0);
        cyc_wait(3);
        bus_read("cmpl_idle_serv", 9'h006, 32'd0);
        bus_read("trig0_pend", 9'h004, 32'd0);
        bus_write(9'h002, 32'd33);
        cyc_wait(3);
        bus_read("trig33_pend", 9'h005, 32'h0000_0002);
        nmi = 1'b1;
        cyc_wait(2);
        chk("nmi_masked", {31'd0, nmi_o}, 32'd0);
        bus_write(9'h001, 32'h0000_0100);
        cyc_wait(1);
        chk("nmi_on", {31'd0, nmi_o}, 32'd1);

        // reset mid-run with sources pending
        irq[5] = 1'b1;
        cyc_wait(3);
        chk("pre_rst_irq", {29'd0, irq_o}, 32'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_irq", {29'd0, irq_o}, 32'd0);
        chk("mid_rst_id", {26'd0, id_o}, 32'd0);
        chk("mid_rst_nmi", {31'd0, nmi_o}, 32'd0);
        cyc_wait(2);
        irq[5] = 1'b0; nmi = 1'b0;
        rst = 1'b0;
        bus_read("post_rst_pend0", 9'h004, 32'd0);
        bus_read("post_rst_pend1", 9'h005, 32'd0);
        bus_read("post_rst_serv0", 9'h006, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
